// File: rtl/rf_ctx_engine.sv
// Register-file context save/restore engine: streams R0..R7 out over valid/ready,
// or loads R0..R7 from a valid/ready stream through the register file write port.
module rf_ctx_engine #(
    parameter int DW   = 16,
    parameter int AW   = 3,
    parameter int NREG = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          save_req,
    input  logic          restore_req,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rf_readregsel,
    input  logic [DW-1:0] rf_readdata,
    output logic [AW-1:0] rf_writeregsel,
    output logic [DW-1:0] rf_writedata,
    output logic          rf_write,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready
);
    typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} state_t;

    state_t        state;
    logic [AW-1:0] idx;
    logic          last;
    logic          out_xfer;
    logic          in_xfer;

    assign last     = (idx == AW'(NREG - 1));
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign out_valid = (state == SAVE) & ~abort;
    assign in_ready  = (state == RESTORE) & ~abort;
    assign out_xfer  = out_valid & out_ready;
    assign in_xfer   = in_valid & in_ready;

    // All outputs decode from the async-reset state, so reset clears them at once.
    assign rf_write       = in_xfer;
    assign rf_readregsel  = (state == SAVE)    ? idx         : '0;
    assign out_data       = (state == SAVE)    ? rf_readdata : '0;
    assign rf_writeregsel = (state == RESTORE) ? idx         : '0;
    assign rf_writedata   = (state == RESTORE) ? in_data     : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    idx <= '0;
                    if (save_req)         state <= SAVE;
                    else if (restore_req) state <= RESTORE;
                end
                SAVE: begin
                    if (abort) begin
                        state <= IDLE;
                        idx   <= '0;
                    end else if (out_xfer) begin
                        idx <= idx + AW'(1);
                        if (last) state <= DONE;
                    end
                end
                RESTORE: begin
                    if (abort) begin
                        state <= IDLE;
                        idx   <= '0;
                    end else if (in_xfer) begin
                        idx <= idx + AW'(1);
                        if (last) state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    idx   <= '0;
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rf_ctx_engine.sv
// Bench for rf_ctx_engine: register-file model, transfer-level reference model,
// directed table/sequence tests and randomized traffic.
module tb_rf_ctx_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        save_req = 1'b0, restore_req = 1'b0, abort = 1'b0;
    logic        busy, done;
    logic [2:0]  rf_readregsel, rf_writeregsel;
    logic [15:0] rf_readdata, rf_writedata;
    logic        rf_write;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] in_data = 16'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;

    rf_ctx_engine #(.DW(16), .AW(3), .NREG(8)) dut (
        .clk(clk), .rst(rst), .save_req(save_req), .restore_req(restore_req),
        .abort(abort), .busy(busy), .done(done),
        .rf_readregsel(rf_readregsel), .rf_readdata(rf_readdata),
        .rf_writeregsel(rf_writeregsel), .rf_writedata(rf_writedata),
        .rf_write(rf_write), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready)
    );

    always #5 clk = ~clk;

    // Register file the engine talks to
    logic [15:0] rf [8];
    assign rf_readdata = rf[rf_readregsel];
    always @(posedge clk) if (rf_write) rf[rf_writeregsel] <= rf_writedata;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
    endtask

    // Reference model: operation in progress (0 none, 1 save, 2 restore, 3 done)
    // and number of words moved; gold is the expected register file content.
    int          m_op = 0, m_cnt = 0;
    logic [15:0] gold [8];

    logic        cap_busy, cap_done, cap_ov, cap_ir, cap_wr;
    logic [2:0]  cap_rsel, cap_wsel;
    logic [15:0] cap_od, cap_wd;

    task automatic cyc(input logic sr, input logic rr, input logic ab,
                       input logic ordy, input logic ivld, input logic [15:0] idat);
        logic e_ov, e_ir;
        @(negedge clk);
        save_req = sr; restore_req = rr; abort = ab;
        out_ready = ordy; in_valid = ivld; in_data = idat;
        #1;
        cap_busy = busy; cap_done = done; cap_ov = out_valid; cap_ir = in_ready;
        cap_wr = rf_write; cap_rsel = rf_readregsel; cap_wsel = rf_writeregsel;
        cap_od = out_data; cap_wd = rf_writedata;
        e_ov = (m_op == 1) && !ab;
        e_ir = (m_op == 2) && !ab;
        chk("busy", cap_busy, m_op != 0);
        chk("done", cap_done, m_op == 3);
        chk("out_valid", cap_ov, e_ov);
        chk("in_ready", cap_ir, e_ir);
        chk("rf_write", cap_wr, e_ir && ivld);
        chk("readsel", cap_rsel, (m_op == 1) ? m_cnt : 0);
        chk("out_data", cap_od, (m_op == 1) ? gold[m_cnt] : 16'h0);
        chk("writesel", cap_wsel, (m_op == 2) ? m_cnt : 0);
        chk("writedata", cap_wd, (m_op == 2) ? idat : 16'h0);
        if (rst) begin
            case (m_op)
                0: begin
                    m_cnt = 0;
                    if (sr) m_op = 1;
                    else if (rr) m_op = 2;
                end
                1, 2: begin
                    if (ab) begin
                        m_op = 0; m_cnt = 0;
                    end else if ((m_op == 1 && ordy) || (m_op == 2 && ivld)) begin
                        if (m_op == 2) gold[m_cnt] = idat;
                        m_cnt++;
                        if (m_cnt == 8) begin m_op = 3; m_cnt = 0; end
                    end
                end
                default: m_op = 0;
            endcase
        end
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic full_restore(input logic [15:0] base);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, base + 16'(i));
    endtask

    typedef struct {
        logic        sr, ordy;
        logic        e_busy, e_done, e_ov;
        logic [2:0]  e_rsel;
        logic [15:0] e_od;
    } vec_t;
    vec_t tbl [11];

    initial begin
        int xfers, dones;
        logic        stalled;
        logic [15:0] held;

        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0};
        for (int i = 1; i <= 8; i++)
            tbl[i] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'(i - 1), 16'(16'h1110 + i - 1)};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0};

        // Reset state
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_rf_write", rf_write, 0);
        @(negedge clk); rst = 1'b1;

        // Preload R0..R7 through a restore, then check it landed
        full_restore(16'h1110);
        idle_cyc(); idle_cyc();
        for (int i = 0; i < 8; i++) chk("preload_rf", rf[i], 16'h1110 + 16'(i));

        // Table-driven save with out_ready held high
        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].sr, 1'b0, 1'b0, tbl[i].ordy, 1'b0, 16'h0);
            chk("tbl_busy", cap_busy, tbl[i].e_busy);
            chk("tbl_done", cap_done, tbl[i].e_done);
            chk("tbl_out_valid", cap_ov, tbl[i].e_ov);
            chk("tbl_readsel", cap_rsel, tbl[i].e_rsel);
            chk("tbl_out_data", cap_od, tbl[i].e_od);
        end

        // Restore A000.., then save streams it back
        full_restore(16'hA000);
        chk("restore_done", done === 1'b0 ? 0 : 1, 0);
        idle_cyc();
        chk("restore_done_pulse", cap_done, 1);
        for (int i = 0; i < 8; i++) chk("restore_rf", rf[i], 16'hA000 + 16'(i));
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
            chk("saveback_data", cap_od, 16'hA000 + 16'(i));
        end
        idle_cyc(); idle_cyc();

        // Save with out_ready pattern 1,0,0: held data, exactly 8 transfers
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        xfers = 0; dones = 0; stalled = 1'b0; held = 16'h0;
        for (int k = 0; k < 30; k++) begin
            cyc(1'b0, 1'b0, 1'b0, (k % 3) == 0, 1'b0, 16'h0);
            if (stalled && cap_ov) chk("stall_hold", cap_od, held);
            if (cap_ov && (k % 3) == 0) begin
                chk("stall_order", cap_od, 16'hA000 + 16'(xfers));
                xfers++;
            end
            stalled = cap_ov && (k % 3) != 0;
            held = cap_od;
            if (cap_done) dones++;
        end
        chk("stall_xfers", xfers, 8);
        chk("stall_dones", dones, 1);

        // save_req and restore_req together: save wins, no writes
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h5555);
        for (int i = 0; i < 9; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'($urandom));
            if (i == 0) chk("both_is_save", cap_ov, 1);
            chk("both_no_write", cap_wr, 0);
        end
        idle_cyc();

        // Abort after the 3rd restore write
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hB000 + 16'(i));
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'hBEEF);
        chk("abort_no_write", cap_wr, 0);
        idle_cyc();
        chk("abort_busy", cap_busy, 0);
        chk("abort_no_done", cap_done, 0);
        for (int i = 0; i < 8; i++)
            chk("abort_rf", rf[i], (i < 3) ? 16'hB000 + 16'(i) : 16'hA000 + 16'(i));

        // restore_req during DONE is ignored
        full_restore(16'hC000);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("done_req_done", cap_done, 1);
        idle_cyc();
        chk("done_req_ignored", cap_busy, 0);

        // Async reset after the 4th save transfer
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        @(posedge clk); #2;
        chk("pre_rst_busy", busy, 1);
        rst = 1'b0; #1;
        m_op = 0; m_cnt = 0;
        chk("arst_busy", busy, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_readsel", rf_readregsel, 0);
        chk("arst_done", done, 0);
        chk("arst_in_ready", in_ready, 0);
        idle_cyc(); idle_cyc();
        @(negedge clk); rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        chk("post_rst_readsel", cap_rsel, 0);
        chk("post_rst_data", cap_od, 16'hC000);
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++)
            cyc($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0,
                $urandom_range(0, 2) != 0, 16'($urandom));
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        idle_cyc();
        for (int i = 0; i < 8; i++) chk("rand_rf", rf[i], gold[i]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
